// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line fetcher.
//   ROM_AW      : sprite ROM address width
//   COORD_W     : screen coordinate width
//   rgb332_t    : RRRGGGBB pixel
//   TRANSPARENT : pixel value that is never written to the line buffer
//   fsm_state_t : fetch sequencer states
package sprite_pkg;

    localparam int ROM_AW  = 15;
    localparam int COORD_W = 11;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    localparam rgb332_t TRANSPARENT = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SEL,
        ST_FETCH,
        ST_DRAIN
    } fsm_state_t;

endpackage

// File: rtl/sprite_line_buf.sv
// Two-bank scanline buffer: one write port, one registered read port.
// The fetcher fills one bank while the display path reads the other.
// Ports:
//   clk, rst            clock, synchronous active-high reset (read register only)
//   wr_en/wr_bank/wr_addr/wr_data   write port
//   rd_en/rd_bank/rd_addr           read request; rd_data is 0 when rd_en was low
//   rd_data             registered read data (1 clk latency)
module sprite_line_buf
    import sprite_pkg::*;
#(
    parameter  int LINE_W = 640,
    localparam int AW     = $clog2(LINE_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    // Storage is intentionally not reset; the fetcher clears a bank before use.
    logic [7:0] mem_q [0:1][0:LINE_W-1];
    logic [7:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bank][wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = TRANSPARENT;
        if (rd_en) begin
            rd_data_d = mem_q[rd_bank][rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sprite_line_fetcher.sv
// Sprite line fetcher: time-shares one sprite ROM among NUM_SPR sprites,
// prefetching the next scanline into a double-buffered line buffer and
// presenting the composited pixel for the current line.
// Optional build macro: SPR_HFLIP_EN (per-sprite horizontal flip via spr_flip).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   line_start      start-of-hblank pulse; next_vc is sampled with it
//   spr_en/x/y/base/flip   packed per-sprite configuration (index 0 wins)
//   rom_addr/rom_data      shared ROM port, data 1 clk after address
//   hc, blank       display position; R/G/B registered 1 clk later
//   busy            prefetch in progress
//   overrun         sticky: line_start seen while busy
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for line_start
// CLEAR    | writing transparent to every write-bank pixel
// SEL      | testing sprite idx for vertical overlap with the line
// FETCH    | issuing IMG_W ROM addresses for the selected sprite row
// DRAIN    | absorbing the last ROM beat before moving to the next sprite
module sprite_line_fetcher
    import sprite_pkg::*;
#(
    parameter int NUM_SPR = 4,
    parameter int IMG_W   = 250,
    parameter int IMG_H   = 100,
    parameter int LINE_W  = 640
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        line_start,
    input  logic [COORD_W-1:0]          next_vc,
    input  logic [NUM_SPR-1:0]          spr_en,
    input  logic [NUM_SPR*COORD_W-1:0]  spr_x,
    input  logic [NUM_SPR*COORD_W-1:0]  spr_y,
    input  logic [NUM_SPR*ROM_AW-1:0]   spr_base,
    input  logic [NUM_SPR-1:0]          spr_flip,
    output logic [ROM_AW-1:0]           rom_addr,
    input  logic [7:0]                  rom_data,
    input  logic [COORD_W-1:0]          hc,
    input  logic                        blank,
    output logic [2:0]                  R,
    output logic [2:0]                  G,
    output logic [1:0]                  B,
    output logic                        busy,
    output logic                        overrun
);

    localparam int IDX_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
    localparam int I_W   = $clog2(IMG_W);
    localparam int CNT_W = $clog2(LINE_W);
    localparam int POS_W = COORD_W + 1;

    fsm_state_t          state_q, state_d;
    logic [COORD_W-1:0]  vc_q, vc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [I_W-1:0]      i_q, i_d;
    logic [ROM_AW-1:0]   row_base_q, row_base_d;
    logic                wb_vld_q, wb_vld_d;
    logic [POS_W-1:0]    wb_pos_q, wb_pos_d;
    logic                disp_bank_q, disp_bank_d;
    logic                overrun_q, overrun_d;

    logic [COORD_W-1:0]  cur_x, cur_y;
    logic [ROM_AW-1:0]   cur_base, fetch_off;
    logic [POS_W-1:0]    vc_ext, y_top, y_end, dy;
    logic                hit;
    logic                wr_en;
    logic [CNT_W-1:0]    wr_addr;
    logic [7:0]          wr_data;
    logic                rd_en;
    logic [7:0]          rd_data;

    assign cur_x    = spr_x[idx_q*COORD_W +: COORD_W];
    assign cur_y    = spr_y[idx_q*COORD_W +: COORD_W];
    assign cur_base = spr_base[idx_q*ROM_AW +: ROM_AW];

    // 12-bit bounds so y near the top of the coordinate range cannot wrap.
    assign vc_ext = {1'b0, vc_q};
    assign y_top  = {1'b0, cur_y};
    assign y_end  = y_top + POS_W'(IMG_H);
    assign dy     = vc_ext - y_top;
    assign hit    = spr_en[idx_q] && (vc_ext >= y_top) && (vc_ext < y_end);

`ifdef SPR_HFLIP_EN
    // Flipped sprites read the row backwards; the write position is unchanged.
    assign fetch_off = spr_flip[idx_q] ? (ROM_AW'(IMG_W - 1) - ROM_AW'(i_q))
                                       : ROM_AW'(i_q);
`else
    logic unused_flip;
    assign unused_flip = ^spr_flip;
    assign fetch_off   = ROM_AW'(i_q);
`endif

    always_comb begin
        state_d     = state_q;
        vc_d        = vc_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        i_d         = i_q;
        row_base_d  = row_base_q;
        wb_vld_d    = 1'b0;
        wb_pos_d    = wb_pos_q;
        disp_bank_d = disp_bank_q;
        overrun_d   = overrun_q;
        rom_addr    = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = TRANSPARENT;

        case (state_q)
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                if (cnt_q == CNT_W'(LINE_W - 1)) begin
                    idx_d   = IDX_W'(NUM_SPR - 1);
                    state_d = ST_SEL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SEL: begin
                if (hit) begin
                    row_base_d = cur_base + ROM_AW'(dy) * ROM_AW'(IMG_W);
                    i_d        = '0;
                    state_d    = ST_FETCH;
                end else if (idx_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_FETCH: begin
                rom_addr = row_base_q + fetch_off;
                wb_vld_d = 1'b1;
                wb_pos_d = {1'b0, cur_x} + POS_W'(i_q);
                if (i_q == I_W'(IMG_W - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (idx_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = ST_SEL;
                end
            end
            default: ;
        endcase

        // Beat for the address issued last cycle; never overlaps CLEAR.
        if (wb_vld_q && (rom_data != TRANSPARENT) && (wb_pos_q < POS_W'(LINE_W))) begin
            wr_en   = 1'b1;
            wr_addr = wb_pos_q[CNT_W-1:0];
            wr_data = rom_data;
        end

        // A new line always wins. Writes this cycle would land in the bank that
        // is about to become the display bank, so they are dropped.
        if (line_start) begin
            overrun_d   = overrun_q | (state_q != ST_IDLE);
            vc_d        = next_vc;
            disp_bank_d = ~disp_bank_q;
            cnt_d       = '0;
            wb_vld_d    = 1'b0;
            wr_en       = 1'b0;
            state_d     = ST_CLEAR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vc_q        <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            i_q         <= '0;
            row_base_q  <= '0;
            wb_vld_q    <= 1'b0;
            wb_pos_q    <= '0;
            disp_bank_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vc_q        <= vc_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            i_q         <= i_d;
            row_base_q  <= row_base_d;
            wb_vld_q    <= wb_vld_d;
            wb_pos_q    <= wb_pos_d;
            disp_bank_q <= disp_bank_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rd_en = !blank && (hc < COORD_W'(LINE_W));

    sprite_line_buf #(
        .LINE_W (LINE_W)
    ) u_line_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_bank (~disp_bank_q),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_bank (disp_bank_q),
        .rd_addr (hc[CNT_W-1:0]),
        .rd_data (rd_data)
    );

    assign {R, G, B} = rd_data;
    assign busy      = (state_q != ST_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
module tb_sprite_line_fetcher;

    localparam int NSPR   = 4;
    localparam int IMG_W  = 250;
    localparam int IMG_H  = 100;
    localparam int LINE_W = 640;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_start;
    logic [10:0] next_vc;
    logic [3:0]  spr_en;
    logic [43:0] spr_x, spr_y;
    logic [59:0] spr_base;
    logic [3:0]  spr_flip;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data;
    logic [10:0] hc;
    logic        blank;
    logic [2:0]  R, G;
    logic [1:0]  B;
    logic        busy, overrun;

    sprite_line_fetcher #(
        .NUM_SPR(NSPR), .IMG_W(IMG_W), .IMG_H(IMG_H), .LINE_W(LINE_W)
    ) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .next_vc(next_vc),
        .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y), .spr_base(spr_base),
        .spr_flip(spr_flip), .rom_addr(rom_addr), .rom_data(rom_data),
        .hc(hc), .blank(blank), .R(R), .G(G), .B(B), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // ROM model: data one clock after the address.
    logic [7:0] rom_mem [0:32767];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int          n_cmp = 0;
    int          n_err = 0;
    logic [18:0] exp_rgb_q [$];   // {hc, expected pixel}
    int          exp_busy_q [$];
    logic        drv_vld = 1'b0;
    logic        mon_vld = 1'b0;
    int          busy_run = 0;
    logic [18:0] e_rgb;
    int          e_busy;

    logic [7:0]  cur_line  [0:LINE_W-1];
    logic [7:0]  prev_line [0:LINE_W-1];
    bit          prev_valid = 0;
    logic [14:0] addr_log [0:4095];

    always @(posedge clk) mon_vld <= drv_vld;

    // Monitor: pixel scoreboard and busy-run-length scoreboard.
    always @(negedge clk) begin
        if (mon_vld) begin
            n_cmp++;
            if (exp_rgb_q.size() == 0) begin
                n_err++;
                $display("FAIL rgb: output with no expectation, got %h", {R, G, B});
            end else begin
                e_rgb = exp_rgb_q.pop_front();
                if ({R, G, B} !== e_rgb[7:0]) begin
                    n_err++;
                    $display("FAIL rgb hc=%0d: got %h expected %h", e_rgb[18:8], {R, G, B}, e_rgb[7:0]);
                end
            end
        end
        if (busy === 1'b1) begin
            busy_run++;
        end else if (busy_run != 0) begin
            n_cmp++;
            if (exp_busy_q.size() == 0) begin
                n_err++;
                $display("FAIL busy_run: unexpected run of %0d cycles", busy_run);
            end else begin
                e_busy = exp_busy_q.pop_front();
                if (busy_run != e_busy) begin
                    n_err++;
                    $display("FAIL busy_run: got %0d cycles expected %0d", busy_run, e_busy);
                end
            end
            busy_run = 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_spr(input int s, input bit en, input int x, input int y,
                           input int base, input bit flip);
        spr_en[s]           = en;
        spr_x[s*11 +: 11]   = 11'(x);
        spr_y[s*11 +: 11]   = 11'(y);
        spr_base[s*15 +: 15] = 15'(base);
        spr_flip[s]         = flip;
    endtask

    // Reference: painter's algorithm, highest index first, transparent skipped.
    function automatic int model_line(input logic [10:0] vc);
        int hits = 0;
        for (int p = 0; p < LINE_W; p++) cur_line[p] = 8'h00;
        for (int s = NSPR - 1; s >= 0; s--) begin
            int x, y, b, a, col, v;
            x = int'(spr_x[s*11 +: 11]);
            y = int'(spr_y[s*11 +: 11]);
            b = int'(spr_base[s*15 +: 15]);
            v = int'(vc);
            if (spr_en[s] && v >= y && v < y + IMG_H) begin
                hits++;
                for (int i = 0; i < IMG_W; i++) begin
                    col = i;
`ifdef SPR_HFLIP_EN
                    if (spr_flip[s]) col = IMG_W - 1 - i;
`endif
                    a = (b + (v - y) * IMG_W + col) % 32768;
                    if (x + i < LINE_W && rom_mem[a] != 8'h00) cur_line[x + i] = rom_mem[a];
                end
            end
        end
        return hits;
    endfunction

    task automatic pulse_line(input logic [10:0] vc);
        next_vc    = vc;
        line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy === 1'b1 && k < 4000) begin
            if (k < 4096) addr_log[k] = rom_addr;
            @(posedge clk); #1;
            k++;
        end
        if (busy !== 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: busy still %b after %0d cycles", busy, k);
        end
    endtask

    task automatic sweep();
        logic [7:0] px;
        bit         bl;
        int         h;
        for (int n = 0; n < LINE_W + 12; n++) begin
            h  = (n < LINE_W + 8) ? n : int'($urandom_range(LINE_W, 2047));
            bl = ($urandom_range(0, 7) == 0);
            px = (bl || h >= LINE_W) ? 8'h00 : prev_line[h];
            hc      = 11'(h);
            blank   = bl;
            drv_vld = 1'b1;
            exp_rgb_q.push_back({11'(h), px});
            @(posedge clk); #1;
        end
        drv_vld = 1'b0;
        blank   = 1'b1;
        hc      = '0;
    endtask

    task automatic run_line(input logic [10:0] vc);
        int hits;
        hits = model_line(vc);
        exp_busy_q.push_back(LINE_W + NSPR + hits * (IMG_W + 1));
        pulse_line(vc);
        fork
            begin
                if (prev_valid) sweep();
            end
            wait_idle();
        join
        prev_line  = cur_line;
        prev_valid = 1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, hits_b, s;
        logic [10:0] vc;

        rst = 1'b1; line_start = 1'b0; next_vc = '0; blank = 1'b1; hc = '0;
        spr_en = '0; spr_x = '0; spr_y = '0; spr_base = '0; spr_flip = '0;
        for (int a = 0; a < 32768; a++) rom_mem[a] = 8'(a);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_rgb", int'({R, G, B}), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_rom_addr", int'(rom_addr), 0);

        // Single sprite, address sweep for row 2.
        rom_mem[500] = 8'h00;
        set_spr(0, 1, 100, 50, 0, 0);
        run_line(11'd52);
        check("addr_first", int'(addr_log[LINE_W + NSPR]), 500);
        check("addr_last", int'(addr_log[LINE_W + NSPR + IMG_W - 1]), 749);
        bad = 0;
        for (int i = 0; i < IMG_W; i++)
            if (int'(addr_log[LINE_W + NSPR + i]) != 500 + i) bad++;
        check("addr_sweep_errors", bad, 0);
        run_line(11'd53);

        // Overlapping sprites: index 0 on top, then index 1 alone.
        spr_en = '0;
        set_spr(0, 1, 10, 0, 2, 0);
        set_spr(1, 1, 10, 0, 1000, 0);
        run_line(11'd0);
        spr_en[0] = 1'b0;
        run_line(11'd1);

        // Right-edge clipping, then a line with no hits.
        spr_en = '0;
        set_spr(0, 1, 600, 200, 3000, 0);
        run_line(11'd210);
        run_line(11'd400);
        check("overrun_clear", int'(overrun), 0);

        // Overrun: second line_start 800 cycles into the first.
        hits_b = model_line(11'd210);
        exp_busy_q.push_back(LINE_W + NSPR + hits_b * (IMG_W + 1));
        pulse_line(11'd210);
        repeat (799) begin @(posedge clk); #1; end
        hits_b = model_line(11'd250);
        void'(exp_busy_q.pop_back());
        exp_busy_q.push_back(800 + LINE_W + NSPR + hits_b * (IMG_W + 1));
        pulse_line(11'd250);
        check("overrun_set", int'(overrun), 1);
        wait_idle();
        prev_line  = cur_line;
        prev_valid = 1;
        run_line(11'd260);
        check("overrun_sticky", int'(overrun), 1);

        // Randomized configurations and ROM contents.
        for (int a = 0; a < 32768; a++)
            rom_mem[a] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        for (int n = 0; n < 12; n++) begin
            for (int t = 0; t < NSPR; t++)
                set_spr(t, 1'($urandom_range(0, 1)), int'($urandom_range(0, 700)),
                        int'($urandom_range(0, 700)), int'($urandom_range(0, 32767)),
                        1'($urandom_range(0, 1)));
            s  = int'($urandom_range(0, NSPR - 1));
            vc = 11'(int'(spr_y[s*11 +: 11]) + int'($urandom_range(0, 110)));
            run_line(vc);
        end

        repeat (4) @(posedge clk);
        #1;
        check("rgb_queue_left", exp_rgb_q.size(), 0);
        check("busy_queue_left", exp_busy_q.size(), 0);
        check("overrun_final", int'(overrun), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
